filter_mode_controller: RTL and testbench

FILTER_MODE_CONTROLLER -- requirements
Module: filter_mode_controller

---
 rtl/filter_mode_controller.sv | 141 ++++++++++++++
 tb/tb_filter_mode_controller.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/filter_mode_controller.sv
// Filter mode selector: a debounced push button steps through the filter modes,
// and each new mode/threshold takes effect only at the end of a complete frame.
module filter_mode_controller #(
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter logic [10:0] LAST_ROW        = 11'd1023
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iKEY,
    input  logic [3:0]  iSW_THR,
    input  logic        iDVAL,
    input  logic [10:0] iX_Cont,
    input  logic [10:0] iY_Cont,
    output logic [1:0]  oMODE,
    output logic [11:0] oTHRESH,
    output logic        oMODE_UPDATE,
    output logic        oPENDING,
    output logic [15:0] oFRAME_CNT
);
    localparam int          CW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PENDING, APPLY} state_t;

    logic          key_meta_q, key_sync_q, key_lvl_q;
    logic [CW-1:0] db_cnt_q;
    logic          dval_q;
    logic [10:0]   y_q;
    state_t        state_q, state_d;
    logic [1:0]    pend_q, pend_d;
    logic [1:0]    mode_q, mode_d;
    logic [11:0]   thr_q, thr_d;
    logic [15:0]   frame_cnt_q;
    logic          press, frame_end;
    logic          unused_x;

    assign unused_x = ^iX_Cont;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            key_meta_q <= 1'b1;
            key_sync_q <= 1'b1;
            key_lvl_q  <= 1'b1;
            db_cnt_q   <= '0;
        end else begin
            key_meta_q <= iKEY;
            key_sync_q <= key_meta_q;
            if (key_sync_q != key_lvl_q) begin
                if (db_cnt_q == DB_MAX) begin
                    key_lvl_q <= key_sync_q;
                    db_cnt_q  <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + 1'b1;
                end
            end else begin
                db_cnt_q <= '0;
            end
        end
    end

    // A press is the cycle the debouncer accepts a new low level.
    assign press = (key_sync_q != key_lvl_q) && (db_cnt_q == DB_MAX) && !key_sync_q;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            dval_q      <= 1'b0;
            y_q         <= '0;
            frame_cnt_q <= '0;
        end else begin
            dval_q <= iDVAL;
            y_q    <= iY_Cont;
            if (frame_end)
                frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_end = dval_q && !iDVAL && (y_q == LAST_ROW);

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q <= IDLE;
            pend_q  <= 2'd0;
            mode_q  <= 2'd0;
            thr_q   <= 12'h800;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            mode_q  <= mode_d;
            thr_q   <= thr_d;
        end
    end

    // Mode/threshold are loaded on entry to APPLY, so they are visible during APPLY.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        mode_d  = mode_q;
        thr_d   = thr_q;
        case (state_q)
            IDLE: begin
                if (press) begin
                    state_d = PENDING;
                    pend_d  = mode_q + 2'd1;
                end
            end
            PENDING: begin
                if (frame_end) begin
                    state_d = APPLY;
                    mode_d  = pend_q;
                    thr_d   = {iSW_THR, 8'h00};
                end else if (press) begin
                    pend_d = pend_q + 2'd1;
                end
            end
            APPLY: begin
                if (press) begin
                    state_d = PENDING;
                    pend_d  = mode_q + 2'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        oMODE_UPDATE = 1'b0;
        oPENDING     = 1'b0;
        case (state_q)
            PENDING: oPENDING     = 1'b1;
            APPLY:   oMODE_UPDATE = 1'b1;
            default: ;
        endcase
    end

    assign oMODE      = mode_q;
    assign oTHRESH    = thr_q;
    assign oFRAME_CNT = frame_cnt_q;

endmodule

// File: tb/tb_filter_mode_controller.sv
// Directed bench for filter_mode_controller with DEBOUNCE_CYCLES=4, LAST_ROW=3.
module tb_filter_mode_controller;
    logic        iCLK = 1'b0;
    logic        iRST = 1'b0;
    logic        iKEY = 1'b1;
    logic [3:0]  iSW_THR = 4'h0;
    logic        iDVAL = 1'b0;
    logic [10:0] iX_Cont = '0;
    logic [10:0] iY_Cont = '0;
    logic [1:0]  oMODE;
    logic [11:0] oTHRESH;
    logic        oMODE_UPDATE;
    logic        oPENDING;
    logic [15:0] oFRAME_CNT;

    int n_chk = 0;
    int n_fail = 0;

    filter_mode_controller #(.DEBOUNCE_CYCLES(4), .LAST_ROW(11'd3)) dut (
        .iCLK(iCLK), .iRST(iRST), .iKEY(iKEY), .iSW_THR(iSW_THR), .iDVAL(iDVAL),
        .iX_Cont(iX_Cont), .iY_Cont(iY_Cont), .oMODE(oMODE), .oTHRESH(oTHRESH),
        .oMODE_UPDATE(oMODE_UPDATE), .oPENDING(oPENDING), .oFRAME_CNT(oFRAME_CNT)
    );

    always #5 iCLK = ~iCLK;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge iCLK);
            #1;
            iX_Cont = iX_Cont + 11'd1;
        end
    endtask

    // Hold the key low long enough to be accepted, then release long enough to be accepted.
    task automatic press_key();
        iKEY = 1'b0;
        tick(10);
        iKEY = 1'b1;
        tick(10);
    endtask

    // One line of valid data on row y, then the falling edge of iDVAL; leaves us one cycle after frame end.
    task automatic frame(input logic [10:0] y);
        iDVAL = 1'b1; iY_Cont = y;
        tick();
        iDVAL = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        iRST = 1'b0;
        tick(2);
        n_chk++; if (oMODE !== 2'd0) begin n_fail++; $display("FAIL reset_mode got %0d want 0", oMODE); end
        n_chk++; if (oTHRESH !== 12'h800) begin n_fail++; $display("FAIL reset_thresh got %h want 800", oTHRESH); end
        n_chk++; if (oPENDING !== 1'b0 || oMODE_UPDATE !== 1'b0) begin n_fail++; $display("FAIL reset_flags got pend=%b upd=%b want 0 0", oPENDING, oMODE_UPDATE); end
        n_chk++; if (oFRAME_CNT !== 16'd0) begin n_fail++; $display("FAIL reset_fcnt got %0d want 0", oFRAME_CNT); end
        iRST = 1'b1;
        tick(2);
    endtask

    task automatic test_short_press();
        logic seen = 1'b0;
        iKEY = 1'b0;
        for (int i = 0; i < 3; i++) begin tick(); seen |= oPENDING; end
        iKEY = 1'b1;
        for (int i = 0; i < 10; i++) begin tick(); seen |= oPENDING; end
        n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL short_press pending got %b want 0", seen); end
    endtask

    task automatic test_apply();
        press_key();
        n_chk++; if (oPENDING !== 1'b1) begin n_fail++; $display("FAIL apply_pending got %b want 1", oPENDING); end
        n_chk++; if (oMODE !== 2'd0) begin n_fail++; $display("FAIL apply_mode_early got %0d want 0", oMODE); end
        iSW_THR = 4'hA;
        iDVAL = 1'b1; iY_Cont = 11'd3;
        tick();
        iDVAL = 1'b0;
        n_chk++; if (oPENDING !== 1'b1 || oMODE_UPDATE !== 1'b0) begin n_fail++; $display("FAIL apply_pre got pend=%b upd=%b want 1 0", oPENDING, oMODE_UPDATE); end
        tick();
        n_chk++; if (oMODE !== 2'd1) begin n_fail++; $display("FAIL apply_mode got %0d want 1", oMODE); end
        n_chk++; if (oTHRESH !== 12'hA00) begin n_fail++; $display("FAIL apply_thresh got %h want a00", oTHRESH); end
        n_chk++; if (oMODE_UPDATE !== 1'b1 || oPENDING !== 1'b0) begin n_fail++; $display("FAIL apply_upd got upd=%b pend=%b want 1 0", oMODE_UPDATE, oPENDING); end
        n_chk++; if (oFRAME_CNT !== 16'd1) begin n_fail++; $display("FAIL apply_fcnt got %0d want 1", oFRAME_CNT); end
        tick();
        n_chk++; if (oMODE_UPDATE !== 1'b0 || oMODE !== 2'd1) begin n_fail++; $display("FAIL apply_after got upd=%b mode=%0d want 0 1", oMODE_UPDATE, oMODE); end
        iSW_THR = 4'h3;
        tick(5);
        n_chk++; if (oTHRESH !== 12'hA00) begin n_fail++; $display("FAIL idle_thresh got %h want a00", oTHRESH); end
    endtask

    task automatic test_wrap();
        press_key();
        frame(11'd3);
        n_chk++; if (oMODE !== 2'd2 || oTHRESH !== 12'h300) begin n_fail++; $display("FAIL wrap_setup got mode=%0d thr=%h want 2 300", oMODE, oTHRESH); end
        tick(2);
        press_key(); press_key(); press_key();
        n_chk++; if (oMODE !== 2'd2 || oPENDING !== 1'b1) begin n_fail++; $display("FAIL wrap_hold got mode=%0d pend=%b want 2 1", oMODE, oPENDING); end
        frame(11'd3);
        n_chk++; if (oMODE !== 2'd1 || oMODE_UPDATE !== 1'b1) begin n_fail++; $display("FAIL wrap_mode got mode=%0d upd=%b want 1 1", oMODE, oMODE_UPDATE); end
        tick(2);
    endtask

    task automatic test_collision();
        press_key();
        // Key low after edge 0 is accepted at edge 6; frame end lands in the same cycle.
        iKEY = 1'b0;
        tick(4);
        iDVAL = 1'b1; iY_Cont = 11'd3;
        tick();
        iDVAL = 1'b0;
        n_chk++; if (oPENDING !== 1'b1) begin n_fail++; $display("FAIL coll_pre got pend=%b want 1", oPENDING); end
        tick();
        n_chk++; if (oMODE !== 2'd2 || oMODE_UPDATE !== 1'b1) begin n_fail++; $display("FAIL coll_mode got mode=%0d upd=%b want 2 1", oMODE, oMODE_UPDATE); end
        tick(8);
        n_chk++; if (oPENDING !== 1'b0) begin n_fail++; $display("FAIL coll_lost got pend=%b want 0", oPENDING); end
        iKEY = 1'b1;
        tick(10);
        n_chk++; if (oPENDING !== 1'b0 || oMODE !== 2'd2) begin n_fail++; $display("FAIL coll_after got pend=%b mode=%0d want 0 2", oPENDING, oMODE); end
    endtask

    task automatic test_partial_and_wrap_count();
        logic [15:0] fc;
        press_key();
        fc = oFRAME_CNT;
        frame(11'd1);
        tick(3);
        n_chk++; if (oFRAME_CNT !== fc) begin n_fail++; $display("FAIL partial_fcnt got %0d want %0d", oFRAME_CNT, fc); end
        n_chk++; if (oPENDING !== 1'b1 || oMODE !== 2'd2) begin n_fail++; $display("FAIL partial_hold got pend=%b mode=%0d want 1 2", oPENDING, oMODE); end
        frame(11'd3);
        n_chk++; if (oMODE !== 2'd3 || oFRAME_CNT !== fc + 16'd1) begin n_fail++; $display("FAIL partial_apply got mode=%0d fcnt=%0d want 3 %0d", oMODE, oFRAME_CNT, fc + 16'd1); end
        tick(2);
        force dut.frame_cnt_q = 16'hFFFF;
        #1;
        release dut.frame_cnt_q;
        frame(11'd3);
        n_chk++; if (oFRAME_CNT !== 16'd0) begin n_fail++; $display("FAIL fcnt_wrap got %h want 0000", oFRAME_CNT); end
        tick(2);
    endtask

    task automatic test_reset_pending();
        press_key();
        n_chk++; if (oPENDING !== 1'b1 || oMODE !== 2'd3) begin n_fail++; $display("FAIL rstp_setup got pend=%b mode=%0d want 1 3", oPENDING, oMODE); end
        #2;
        iRST = 1'b0;
        #1;
        n_chk++; if (oMODE !== 2'd0 || oTHRESH !== 12'h800) begin n_fail++; $display("FAIL rstp_async got mode=%0d thr=%h want 0 800", oMODE, oTHRESH); end
        n_chk++; if (oPENDING !== 1'b0 || oMODE_UPDATE !== 1'b0 || oFRAME_CNT !== 16'd0) begin n_fail++; $display("FAIL rstp_flags got pend=%b upd=%b fcnt=%0d want 0 0 0", oPENDING, oMODE_UPDATE, oFRAME_CNT); end
        tick(2);
        iRST = 1'b1;
        tick(2);
        press_key();
        frame(11'd3);
        n_chk++; if (oMODE !== 2'd1) begin n_fail++; $display("FAIL rstp_first got mode=%0d want 1", oMODE); end
    endtask

    initial begin
        tick();
        test_reset();
        test_short_press();
        test_apply();
        test_wrap();
        test_collision();
        test_partial_and_wrap_count();
        test_reset_pending();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
